// File: rtl/lemming_world.sv
// Environment model for the lemming walker: tracks x-position and level, and generates bump/ground feedback.
// Latency: bump/landed are one-cycle registered pulses; ground/level are decoded from state only; no backpressure.
module lemming_world #(
    parameter int PW          = 4,
    parameter int START_POS   = 4,
    parameter int LEFT_WALL   = 0,
    parameter int RIGHT_WALL  = 15,
    parameter int HOLE_LO     = 9,
    parameter int HOLE_HI     = 10,
    parameter int FALL_CYCLES = 3,
    parameter int STEP_DIV    = 2
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    output logic          bump_left,
    output logic          bump_right,
    output logic          ground,
    output logic [PW-1:0] pos,
    output logic          level,
    output logic          landed
);

    localparam int SCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int FCW = (FALL_CYCLES > 1) ? $clog2(FALL_CYCLES) : 1;

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        FALL   = 2'd1,
        BOTTOM = 2'd2
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  pos_q;
    logic [SCW-1:0] sc_q;
    logic [FCW-1:0] fc_q;
    logic           bump_left_q;
    logic           bump_right_q;
    logic           landed_q;

    logic in_hole;
    logic dir_vld;
    logic may_walk;

    assign in_hole  = (pos_q >= PW'(HOLE_LO)) && (pos_q <= PW'(HOLE_HI));
    assign dir_vld  = (walk_left ^ walk_right) && !aaah;
    // The edge that drops the lemming into the hole must not also move it.
    assign may_walk = (state_q == BOTTOM) || (state_q == TOP && !in_hole);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= TOP;
            pos_q        <= PW'(START_POS);
            sc_q         <= '0;
            fc_q         <= '0;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            landed_q     <= 1'b0;
        end else begin
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            landed_q     <= 1'b0;

            case (state_q)
                TOP: begin
                    if (in_hole) begin
                        state_q <= FALL;
                        fc_q    <= FCW'(FALL_CYCLES - 1);
                        sc_q    <= '0;
                    end
                end
                FALL: begin
                    sc_q <= '0;
                    if (fc_q != '0) begin
                        fc_q <= fc_q - FCW'(1);
                    end else begin
                        state_q  <= BOTTOM;
                        landed_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (may_walk) begin
                if (!dir_vld) begin
                    sc_q <= '0;
                end else if (sc_q == SCW'(STEP_DIV - 1)) begin
                    sc_q <= '0;
                    if (walk_left) begin
                        if (pos_q > PW'(LEFT_WALL)) pos_q <= pos_q - PW'(1);
                        else                        bump_left_q <= 1'b1;
                    end else begin
                        if (pos_q < PW'(RIGHT_WALL)) pos_q <= pos_q + PW'(1);
                        else                         bump_right_q <= 1'b1;
                    end
                end else begin
                    sc_q <= sc_q + SCW'(1);
                end
            end
        end
    end

    assign pos        = pos_q;
    assign bump_left  = bump_left_q;
    assign bump_right = bump_right_q;
    assign landed     = landed_q;
    assign level      = (state_q == BOTTOM);
    assign ground     = (state_q == TOP) ? !in_hole : (state_q == BOTTOM);

endmodule

// File: tb/tb_lemming_world.sv
// Directed bench for lemming_world: vector tables for walking/fall sequences, hand sequences for wall bumps and mid-fall reset.
module tb_lemming_world;

    logic       clk = 1'b0;
    logic       areset;
    logic       walk_left, walk_right, aaah;
    logic       bump_left, bump_right, ground, level, landed;
    logic [3:0] pos;

    int n_tests = 0;
    int n_fail  = 0;

    lemming_world dut (
        .clk        (clk),
        .areset     (areset),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .pos        (pos),
        .level      (level),
        .landed     (landed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, wl, wr, ah;
        logic [3:0] pos;
        logic       g, lvl, bl, br, ld;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t v(logic rst, logic wl, logic wr, logic ah, logic [3:0] p,
                               logic g, logic lvl, logic bl, logic br, logic ld);
        vec_t r;
        r.rst = rst; r.wl = wl; r.wr = wr; r.ah = ah; r.pos = p;
        r.g = g; r.lvl = lvl; r.bl = bl; r.br = br; r.ld = ld;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".pos"},    pos,        e.pos);
        chk({tag, ".ground"}, ground,     e.g);
        chk({tag, ".level"},  level,      e.lvl);
        chk({tag, ".bump_l"}, bump_left,  e.bl);
        chk({tag, ".bump_r"}, bump_right, e.br);
        chk({tag, ".landed"}, landed,     e.ld);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic apply(input string tag, input vec_t e);
        @(negedge clk);
        areset = e.rst; walk_left = e.wl; walk_right = e.wr; aaah = e.ah;
        @(posedge clk);
        #1;
        chk_all(tag, e);
    endtask

    task automatic tick(input logic wl, input logic wr);
        @(negedge clk);
        areset = 1'b0; walk_left = wl; walk_right = wr; aaah = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Walk right from reset into the hole, fall, land, take one step on the bottom.
        tab_a.push_back(v(1,0,0,0, 4, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 4, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 5, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 5, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 6, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 6, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 7, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 7, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 8, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 8, 1,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 9, 0,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 9, 0,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 9, 0,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 9, 0,0,0,0,0));
        tab_a.push_back(v(0,0,1,0, 9, 1,1,0,0,1));
        tab_a.push_back(v(0,0,1,0, 9, 1,1,0,0,0));
        tab_a.push_back(v(0,0,1,0,10, 1,1,0,0,0));

        // Walk left into the left wall.
        tab_b.push_back(v(1,0,0,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 3, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 3, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 2, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 2, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 1, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 1, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 0, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 0, 1,0,0,0,0));
        tab_b.push_back(v(0,1,0,0, 0, 1,0,1,0,0));
        tab_b.push_back(v(0,1,0,0, 0, 1,0,0,0,0));
        // Both directions: no movement, step counter cleared.
        tab_b.push_back(v(1,0,0,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 4, 1,0,0,0,0));
        for (int i = 0; i < 6; i++) tab_b.push_back(v(0,1,1,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 5, 1,0,0,0,0));
        // aaah blocks walking on TOP and clears the step counter.
        tab_b.push_back(v(1,0,0,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 4, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 5, 1,0,0,0,0));
        for (int i = 0; i < 5; i++) tab_b.push_back(v(0,0,1,1, 5, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 5, 1,0,0,0,0));
        tab_b.push_back(v(0,0,1,0, 6, 1,0,0,0,0));

        areset = 1'b1; walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0;
        #1;
        chk("reset.pos",    pos,    4);
        chk("reset.ground", ground, 1);
        chk("reset.level",  level,  0);
        chk("reset.bumps",  {bump_left, bump_right}, 0);
        chk("reset.landed", landed, 0);

        foreach (tab_a[i]) apply($sformatf("a%0d", i), tab_a[i]);

        // From BOTTOM at pos 10 (step counter at 0): walk to the right wall.
        for (int p = 11; p <= 15; p++) begin
            tick(1'b0, 1'b1);
            chk($sformatf("rw.pos%0d_a", p), pos, p - 1);
            tick(1'b0, 1'b1);
            chk($sformatf("rw.pos%0d_b", p), pos, p);
            chk($sformatf("rw.level%0d", p), level, 1);
        end
        tick(1'b0, 1'b1);
        chk("rw.pre_bump", bump_right, 0);
        tick(1'b0, 1'b1);
        chk("rw.bump_r",   bump_right, 1);
        chk("rw.bump_l",   bump_left,  0);
        chk("rw.bump_pos", pos,        15);
        tick(1'b0, 1'b1);
        chk("rw.bump_end", bump_right, 0);
        chk("rw.pos_hold", pos,        15);

        foreach (tab_b[i]) apply($sformatf("b%0d", i), tab_b[i]);

        // Reset asserted during the second FALL cycle.
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        chk("mf.pos9",   pos,    9);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("mf.falling", ground, 0);
        #2;
        areset = 1'b1;
        #1;
        chk("mf.ground", ground, 1);
        chk("mf.pos",    pos,    4);
        chk("mf.level",  level,  0);
        @(negedge clk);
        areset = 1'b0; walk_right = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            chk($sformatf("mf.landed%0d", i), landed, 0);
            chk($sformatf("mf.lvl%0d", i),    level,  0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
